// File: rtl/pixel_pwm_drive.sv
// Pixel PWM drive: plays a double-buffered {therm[14:0], lsb[3:0]} code as a
// 1-bit time-modulated waveform, frame after frame (15 coarse slots + fine segment).
module pixel_pwm_drive #(
    parameter int PWM_NUM   = 19,
    parameter int SLOT_LEN  = 16,
    parameter int FINE_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PWM_NUM-1:0] in_code,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic               blank,
    output logic               pwm_out,
    output logic               frame_start,
    output logic               err_therm
);

    localparam int CNT_W    = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int FINE_LEN = 16 * FINE_STEP;
    localparam int FCNT_W   = $clog2(FINE_LEN);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT_LEN - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FINE_LEN - 1);
    localparam logic [3:0]        SLOT_LAST = 4'd14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2
    } state_t;

    // A legal thermometer field is 2^n-1: adding one clears every set bit.
    function automatic logic is_therm(input logic [14:0] t);
        return ((t & (t + 15'd1)) == 15'd0);
    endfunction

    state_t             state_r, state_s;
    logic [3:0]         slot_r, slot_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [FCNT_W-1:0]  fcnt_r, fcnt_s;
    logic [18:0]        active_r, active_s;
    logic [18:0]        shadow_r, shadow_s;
    logic               shadow_full_r, shadow_full_s;
    logic               err_r, err_s;
    logic               pwm_r, pwm_s;
    logic               fs_r, fs_s;
    logic               accept_s;
    logic [14:0]        act_therm_s;
    logic [FCNT_W:0]    fine_thr_s;

    assign accept_s    = in_vld & ~shadow_full_r;
    assign act_therm_s = active_r[18:4];
    assign fine_thr_s  = (FCNT_W + 1)'(active_r[3:0]) * (FCNT_W + 1)'(FINE_STEP);

    // Next-state, shadow handoff and registered-output decode.
    always_comb begin
        state_s       = state_r;
        slot_s        = slot_r;
        cnt_s         = cnt_r;
        fcnt_s        = fcnt_r;
        active_s      = active_r;
        shadow_s      = shadow_r;
        shadow_full_s = shadow_full_r;
        err_s         = err_r;
        pwm_s         = 1'b0;
        fs_s          = 1'b0;

        if (accept_s) begin
            shadow_s      = in_code[18:0];
            shadow_full_s = 1'b1;
            if (!is_therm(in_code[18:4])) begin
                err_s = 1'b1;
            end else begin
                err_s = err_r;
            end
        end else begin
            shadow_s = shadow_r;
        end

        case (state_r)
            IDLE: begin
                if (shadow_full_r) begin
                    active_s      = shadow_r;
                    shadow_full_s = 1'b0;
                    state_s       = COARSE;
                    slot_s        = 4'd0;
                    cnt_s         = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            COARSE: begin
                pwm_s = act_therm_s[slot_r] & ~blank;
                fs_s  = (slot_r == 4'd0) && (cnt_r == '0);
                if (cnt_r == CNT_LAST) begin
                    cnt_s = '0;
                    if (slot_r == SLOT_LAST) begin
                        state_s = FINE;
                        slot_s  = 4'd0;
                        fcnt_s  = '0;
                    end else begin
                        slot_s = slot_r + 4'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            FINE: begin
                pwm_s = ({1'b0, fcnt_r} < fine_thr_s) & ~blank;
                if (fcnt_r == FCNT_LAST) begin
                    // Frame boundary: a code accepted on this same edge waits one frame.
                    state_s = COARSE;
                    slot_s  = 4'd0;
                    cnt_s   = '0;
                    fcnt_s  = '0;
                    if (shadow_full_r) begin
                        active_s      = shadow_r;
                        shadow_full_s = 1'b0;
                    end else begin
                        active_s = active_r;
                    end
                end else begin
                    fcnt_s = fcnt_r + FCNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            slot_r        <= 4'd0;
            cnt_r         <= '0;
            fcnt_r        <= '0;
            active_r      <= 19'd0;
            shadow_r      <= 19'd0;
            shadow_full_r <= 1'b0;
            err_r         <= 1'b0;
            pwm_r         <= 1'b0;
            fs_r          <= 1'b0;
        end else begin
            state_r       <= state_s;
            slot_r        <= slot_s;
            cnt_r         <= cnt_s;
            fcnt_r        <= fcnt_s;
            active_r      <= active_s;
            shadow_r      <= shadow_s;
            shadow_full_r <= shadow_full_s;
            err_r         <= err_s;
            pwm_r         <= pwm_s;
            fs_r          <= fs_s;
        end
    end

    assign in_rdy      = ~shadow_full_r;
    assign pwm_out     = pwm_r;
    assign frame_start = fs_r;
    assign err_therm   = err_r;

endmodule

// File: tb/tb_pixel_pwm_drive.sv
// Self-checking bench for pixel_pwm_drive: directed scenarios plus random traffic,
// compared every cycle against a frame-position reference model.
module tb_pixel_pwm_drive;

    localparam int SL = 4;
    localparam int FS = 1;
    localparam int F  = 15 * SL + 16 * FS;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] in_code;
    logic        in_vld;
    logic        in_rdy;
    logic        blank;
    logic        pwm_out;
    logic        frame_start;
    logic        err_therm;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: running flag, position of the frame in progress, buffers.
    bit          m_run;
    int          m_q;
    logic [18:0] m_active;
    logic [18:0] m_shadow;
    bit          m_full;
    bit          m_err;
    bit          m_pwm;
    bit          m_fs;

    always #5 clk = ~clk;

    pixel_pwm_drive #(
        .PWM_NUM   (19),
        .SLOT_LEN  (SL),
        .FINE_STEP (FS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_code     (in_code),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .blank       (blank),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .err_therm   (err_therm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit therm_ok(input logic [14:0] t);
        for (int n = 0; n <= 15; n++) begin
            if (32'(t) == ((32'd1 << n) - 32'd1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drive level at frame position q for code c (blank applied separately).
    function automatic bit level(input int q, input logic [18:0] c);
        if (q < 15 * SL) return c[4 + q / SL];
        return (q - 15 * SL) < (int'(c[3:0]) * FS);
    endfunction

    // Predict the effect of the coming clock edge with the inputs now applied.
    task automatic model_edge();
        bit acc;
        if (rst) begin
            m_run = 0; m_q = 0; m_active = '0; m_shadow = '0;
            m_full = 0; m_err = 0; m_pwm = 0; m_fs = 0;
        end else begin
            acc   = in_vld && !m_full;
            m_pwm = m_run && !blank && level(m_q, m_active);
            m_fs  = m_run && (m_q == 0);
            if (!m_run) begin
                if (m_full) begin
                    m_active = m_shadow; m_full = 0; m_run = 1; m_q = 0;
                end
            end else if (m_q == F - 1) begin
                m_q = 0;
                if (m_full) begin
                    m_active = m_shadow; m_full = 0;
                end
            end else begin
                m_q++;
            end
            if (acc) begin
                m_shadow = in_code; m_full = 1;
                if (!therm_ok(in_code[18:4])) m_err = 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("in_rdy", 32'(in_rdy), 32'(!m_full));
        check("err_therm", 32'(err_therm), 32'(m_err));
    endtask

    task automatic send(input logic [18:0] c);
        in_code = c;
        in_vld  = 1'b1;
        tick();
        in_vld  = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        int guard = 0;
        while (!(m_run && m_q == target) && guard < 2 * F) begin
            tick();
            guard++;
        end
        if (guard >= 2 * F) check("wait_pos_timeout", 32'd1, 32'd0);
    endtask

    // Find the next frame_start, count high cycles over one frame, check period.
    task automatic measure(input logic [18:0] c, input string tag);
        int guard = 0;
        int highs = 0;
        while (frame_start !== 1'b1 && guard < 3 * F) begin
            tick();
            guard++;
        end
        check({tag, "_fs_seen"}, 32'(frame_start), 32'd1);
        for (int i = 0; i < F; i++) begin
            highs += int'(pwm_out);
            tick();
        end
        check({tag, "_period"}, 32'(frame_start), 32'd1);
        check({tag, "_highs"}, 32'(highs), 32'($countones(c[18:4]) * SL + int'(c[3:0]) * FS));
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_code = '0; blank = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_rdy", 32'(in_rdy), 32'd1);
        check("reset_fs", 32'(frame_start), 32'd0);

        // First frame out of IDLE: frame_start two cycles after the accept edge.
        send({15'h03FF, 4'h5});
        tick();
        check("lat_fs_early", 32'(frame_start), 32'd0);
        tick();
        check("lat_fs", 32'(frame_start), 32'd1);
        check("lat_pwm", 32'(pwm_out), 32'd1);
        measure({15'h03FF, 4'h5}, "c3ff5");
        measure({15'h03FF, 4'h5}, "c3ff5_rep");

        wait_pos(10);
        send(19'd0);
        measure(19'd0, "zero");

        wait_pos(10);
        send({15'h7FFF, 4'hF});
        measure({15'h7FFF, 4'hF}, "full");

        // Second code while the shadow is occupied is dropped.
        wait_pos(20);
        send({15'h000F, 4'h3});
        check("shadow_busy", 32'(in_rdy), 32'd0);
        send({15'h0001, 4'h1});
        measure({15'h000F, 4'h3}, "codeA");

        // Blank inside a high coarse slot.
        wait_pos(10);
        send({15'h7FFF, 4'hF});
        measure({15'h7FFF, 4'hF}, "pre_blank");
        wait_pos(6);
        blank = 1'b1;
        repeat (10) tick();
        blank = 1'b0;
        measure({15'h7FFF, 4'hF}, "post_blank");

        // Non-thermometer field: sticky error but still played bitwise.
        wait_pos(10);
        send({15'h0005, 4'h6});
        measure({15'h0005, 4'h6}, "bad_therm");
        repeat (F) tick();
        check("err_sticky", 32'(err_therm), 32'd1);

        // Reset during the fine segment.
        wait_pos(15 * SL + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_rdy", 32'(in_rdy), 32'd1);
        check("rst_err", 32'(err_therm), 32'd0);
        repeat (2 * F) tick();

        // Random traffic: codes, valid pulses, blank bursts, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1) == 0)
                in_code = {15'(((32'd1 << $urandom_range(0, 15)) - 32'd1)), 4'($urandom_range(0, 15))};
            else
                in_code = 19'($urandom);
            in_vld = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) blank = ~blank;
            rst = ($urandom_range(0, 1499) == 0);
            tick();
        end
        rst = 1'b0; in_vld = 1'b0; blank = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
